// File: rtl/sysserv_apb_initiator.sv
// rtl/sysserv_apb_initiator.sv - APB3 master: service request, status poll, mailbox readback.
// Optional poll timeout enabled by defining SYSSERV_TIMEOUT_EN.
module sysserv_apb_initiator #(
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0004,
  parameter logic [31:0] MBX_ADDR    = 32'h0000_0100,
  parameter logic [31:0] TIMEOUT_CYC = 32'h0010_0000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        CMD_START,
  input  logic [7:0]  CMD_OPCODE,
  input  logic [3:0]  CMD_NWORDS,
  output logic        CMD_BUSY,
  output logic        CMD_DONE,
  output logic        CMD_ERROR,
  output logic [7:0]  CMD_STATUS,
  output logic [31:0] RSP_DATA,
  output logic        RSP_VALID,
  output logic [31:0] APBM_PADDR,
  output logic        APBM_PSEL,
  output logic        APBM_PENABLE,
  output logic        APBM_PWRITE,
  output logic [31:0] APBM_PWDATA,
  input  logic [31:0] APBM_PRDATA,
  input  logic        APBM_PREADY,
  input  logic        APBM_PSLVERR
);

  typedef enum logic [2:0] {S_IDLE, S_WR_CMD, S_POLL, S_GAP, S_RD_MBX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [7:0]  opcode_q, opcode_d, status_q, status_d;
  logic [3:0]  nwords_q, nwords_d, idx_q, idx_d, idx_next;
  logic        err_q, err_d, rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        poll_timeout;

`ifdef SYSSERV_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // WR_CMD always precedes the first poll, so clearing there clears at POLL entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_WR_CMD) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_POLL || state_q == S_GAP) && tmo_cnt_q != '1) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end

  assign poll_timeout = (tmo_cnt_q >= TIMEOUT_CYC);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign poll_timeout       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    opcode_d    = opcode_q;
    nwords_d    = nwords_q;
    idx_d       = idx_q;
    status_d    = status_q;
    err_d       = err_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    idx_next    = idx_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        if (CMD_START) begin
          opcode_d  = CMD_OPCODE;
          nwords_d  = CMD_NWORDS;
          idx_d     = '0;
          status_d  = '0;
          err_d     = 1'b0;
          state_d   = S_WR_CMD;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = CTRL_ADDR;
          pwrite_d  = 1'b1;
          pwdata_d  = {23'b0, CMD_OPCODE, 1'b1};
        end
      end
      S_WR_CMD, S_POLL, S_RD_MBX: begin
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (APBM_PREADY) begin
          penable_d = 1'b0;
          if (APBM_PSLVERR) begin
            psel_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (state_q == S_WR_CMD) begin
            state_d  = S_POLL;
            paddr_d  = STATUS_ADDR;
            pwrite_d = 1'b0;
            pwdata_d = '0;
          end else if (state_q == S_POLL) begin
            if (APBM_PRDATA[0]) begin
              psel_d = 1'b0;
              if (poll_timeout) begin
                err_d    = 1'b1;
                status_d = 8'hFF;
                state_d  = S_DONE;
              end else begin
                state_d = S_GAP;
              end
            end else begin
              status_d = APBM_PRDATA[15:8];
              if (APBM_PRDATA[15:8] != 8'h00) begin
                psel_d  = 1'b0;
                err_d   = 1'b1;
                state_d = S_DONE;
              end else if (nwords_q == 4'd0) begin
                psel_d  = 1'b0;
                state_d = S_DONE;
              end else begin
                state_d = S_RD_MBX;
                idx_d   = '0;
                paddr_d = MBX_ADDR;
              end
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = APBM_PRDATA;
            if (idx_next == nwords_q) begin
              psel_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              idx_d   = idx_next;
              paddr_d = MBX_ADDR + {26'b0, idx_next, 2'b00};
            end
          end
        end
      end
      S_GAP: begin
        if (poll_timeout) begin
          err_d    = 1'b1;
          status_d = 8'hFF;
          state_d  = S_DONE;
        end else begin
          psel_d  = 1'b1;
          state_d = S_POLL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      opcode_q    <= '0;
      nwords_q    <= '0;
      idx_q       <= '0;
      status_q    <= '0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      opcode_q    <= opcode_d;
      nwords_q    <= nwords_d;
      idx_q       <= idx_d;
      status_q    <= status_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Busy covers the accept cycle itself, before the state register moves.
  assign CMD_BUSY     = (state_q != S_IDLE) || CMD_START;
  assign CMD_DONE     = (state_q == S_DONE);
  assign CMD_ERROR    = err_q;
  assign CMD_STATUS   = status_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_VALID    = rsp_valid_q;
  assign APBM_PADDR   = paddr_q;
  assign APBM_PSEL    = psel_q;
  assign APBM_PENABLE = penable_q;
  assign APBM_PWRITE  = pwrite_q;
  assign APBM_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_sysserv_apb_initiator.sv
// tb/tb_sysserv_apb_initiator.sv - scoreboard bench with behavioural APB slave for sysserv_apb_initiator.
module tb_sysserv_apb_initiator;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        CMD_START = 1'b0;
  logic [7:0]  CMD_OPCODE = '0;
  logic [3:0]  CMD_NWORDS = '0;
  logic        CMD_BUSY, CMD_DONE, CMD_ERROR, RSP_VALID;
  logic [7:0]  CMD_STATUS;
  logic [31:0] RSP_DATA, APBM_PADDR, APBM_PWDATA;
  logic        APBM_PSEL, APBM_PENABLE, APBM_PWRITE;
  logic [31:0] APBM_PRDATA = '0;
  logic        APBM_PREADY = 1'b0;
  logic        APBM_PSLVERR = 1'b0;

  sysserv_apb_initiator #(.TIMEOUT_CYC(32'd64)) dut (
    .CLK(CLK), .RESETN(RESETN), .CMD_START(CMD_START), .CMD_OPCODE(CMD_OPCODE),
    .CMD_NWORDS(CMD_NWORDS), .CMD_BUSY(CMD_BUSY), .CMD_DONE(CMD_DONE), .CMD_ERROR(CMD_ERROR),
    .CMD_STATUS(CMD_STATUS), .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID),
    .APBM_PADDR(APBM_PADDR), .APBM_PSEL(APBM_PSEL), .APBM_PENABLE(APBM_PENABLE),
    .APBM_PWRITE(APBM_PWRITE), .APBM_PWDATA(APBM_PWDATA), .APBM_PRDATA(APBM_PRDATA),
    .APBM_PREADY(APBM_PREADY), .APBM_PSLVERR(APBM_PSLVERR)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  typedef struct {
    bit          is_done;
    logic [31:0] data;
    logic        err;
    logic [7:0]  status;
  } exp_t;
  exp_t exp_q[$];

  int          sl_busy, sl_waits, sl_err_idx;
  logic [7:0]  sl_code, sl_op;
  logic [31:0] mbx [16];
  int          n_wr, n_poll, n_mbx, wait_cnt;
  bit          prev_setup, stable_ok;
  logic [31:0] s_addr, s_wdata;
  logic        s_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave: waits, status sequence, mailbox contents and error injection come from sl_* knobs.
  initial forever begin
    @(negedge CLK);
    APBM_PREADY  = 1'b0;
    APBM_PSLVERR = 1'b0;
    if (!RESETN) begin
      prev_setup = 1'b0;
      wait_cnt   = 0;
    end else if (APBM_PSEL && !APBM_PENABLE) begin
      chk("no_double_setup", 32'(prev_setup), 32'd0);
      prev_setup = 1'b1;
      s_addr = APBM_PADDR; s_write = APBM_PWRITE; s_wdata = APBM_PWDATA;
      stable_ok = 1'b1;
      wait_cnt  = 0;
    end else if (APBM_PSEL && APBM_PENABLE) begin
      prev_setup = 1'b0;
      if (APBM_PADDR !== s_addr || APBM_PWRITE !== s_write || APBM_PWDATA !== s_wdata)
        stable_ok = 1'b0;
      if (wait_cnt < sl_waits) begin
        wait_cnt++;
      end else begin
        APBM_PREADY = 1'b1;
        chk("access_stable", 32'(stable_ok), 32'd1);
        if (APBM_PWRITE) begin
          n_wr++;
          chk("wr_addr", APBM_PADDR, 32'h0);
          chk("wr_data", APBM_PWDATA, {23'b0, sl_op, 1'b1});
        end else if (APBM_PADDR == 32'h4) begin
          if (n_poll < sl_busy) APBM_PRDATA = $urandom() | 32'h1;
          else APBM_PRDATA = {16'($urandom()), sl_code, 7'($urandom()), 1'b0};
          n_poll++;
        end else begin
          chk("mbx_addr", APBM_PADDR, 32'h100 + 32'(4 * n_mbx));
          APBM_PRDATA = mbx[n_mbx % 16];
          if (n_mbx == sl_err_idx) APBM_PSLVERR = 1'b1;
          n_mbx++;
        end
      end
    end else begin
      prev_setup = 1'b0;
    end
  end

  // Monitor: every DUT response is matched against the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESETN && RSP_VALID) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got word %h while none expected", RSP_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", RSP_DATA, e.data);
        end
      end
      if (RESETN && CMD_DONE) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL done_early: got CMD_DONE with %0d items still expected", exp_q.size());
        end else begin
          e = exp_q.pop_front();
          chk("done_error", 32'(CMD_ERROR), 32'(e.err));
          chk("done_status", 32'(CMD_STATUS), 32'(e.status));
        end
      end
    end
  end

  task automatic run_cmd(input logic [7:0] op, input logic [3:0] n, input int busy,
                         input logic [7:0] code, input int waits, input int err_idx,
                         input bit poke, input bit lat, input bit tmo);
    int exp_m, exp_rsp, t, start_cyc;
    bit exp_err, idle_ok;
    logic [7:0] exp_status;
    exp_t e;
    sl_op = op; sl_busy = busy; sl_code = code; sl_waits = waits; sl_err_idx = err_idx;
    n_wr = 0; n_poll = 0; n_mbx = 0;
    for (int i = 0; i < 16; i++) mbx[i] = $urandom();
    exp_status = code;
    if (tmo) begin
      exp_m = 0; exp_rsp = 0; exp_err = 1'b1; exp_status = 8'hFF;
    end else if (code != 8'h00) begin
      exp_m = 0; exp_rsp = 0; exp_err = 1'b1;
    end else if (err_idx < int'(n)) begin
      exp_m = err_idx + 1; exp_rsp = err_idx; exp_err = 1'b1;
    end else begin
      exp_m = int'(n); exp_rsp = int'(n); exp_err = 1'b0;
    end
    for (int i = 0; i < exp_rsp; i++) begin
      e.is_done = 1'b0; e.data = mbx[i]; e.err = 1'b0; e.status = '0;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1; e.data = '0; e.err = exp_err; e.status = exp_status;
    exp_q.push_back(e);

    @(posedge CLK); #1;
    CMD_OPCODE = op; CMD_NWORDS = n; CMD_START = 1'b1; start_cyc = cyc;
    #1 chk("busy_at_accept", 32'(CMD_BUSY), 32'd1);
    @(posedge CLK); #1;
    CMD_START = 1'b0; CMD_OPCODE = 8'($urandom()); CMD_NWORDS = 4'($urandom());
    if (poke) begin
      repeat (2) @(posedge CLK);
      #1 CMD_START = 1'b1;
      @(posedge CLK); #1 CMD_START = 1'b0;
    end
    t = 0;
    while (!CMD_DONE && t < 4000) begin
      @(negedge CLK);
      t++;
    end
    chk("done_seen", 32'(t < 4000), 32'd1);
    if (lat) chk("min_latency", 32'(cyc - start_cyc), 32'd5);
    chk("busy_at_done", 32'(CMD_BUSY), 32'd1);
    CMD_START = 1'b1;
    @(posedge CLK); #1 CMD_START = 1'b0;
    #1 chk("busy_after_done", 32'(CMD_BUSY), 32'd0);
    chk("n_wr", 32'(n_wr), 32'd1);
    if (!tmo) chk("n_poll", 32'(n_poll), 32'(busy + 1));
    chk("n_mbx", 32'(n_mbx), 32'(exp_m));
    idle_ok = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (APBM_PSEL || CMD_BUSY) idle_ok = 1'b0;
    end
    chk("idle_after_done", 32'(idle_ok), 32'd1);
    chk("status_held", 32'(CMD_STATUS), 32'(exp_status));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {25'b0, APBM_PSEL, APBM_PENABLE, APBM_PWRITE, CMD_BUSY, CMD_DONE,
                       CMD_ERROR, RSP_VALID}, 32'd0);
    chk({tag, "_paddr"}, APBM_PADDR, 32'd0);
    chk({tag, "_pwdata"}, APBM_PWDATA, 32'd0);
    chk({tag, "_rsp_data"}, RSP_DATA, 32'd0);
    chk({tag, "_status"}, 32'(CMD_STATUS), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    sl_busy = 0; sl_waits = 0; sl_err_idx = 99; sl_code = 0; sl_op = 0;
    n_wr = 0; n_poll = 0; n_mbx = 0; wait_cnt = 0; prev_setup = 0; stable_ok = 1;
    repeat (3) @(negedge CLK);
    chk_outputs_zero("reset");
    RESETN = 1'b1;

    run_cmd(8'h00, 4'd4, 3, 8'h00, 0, 99, 1'b0, 1'b0, 1'b0);
    run_cmd(8'h5A, 4'd0, 0, 8'h00, 3, 99, 1'b1, 1'b0, 1'b0);
    run_cmd(8'h11, 4'd0, 0, 8'h00, 0, 99, 1'b0, 1'b1, 1'b0);
    run_cmd(8'h22, 4'd4, 1, 8'h05, 0, 99, 1'b0, 1'b0, 1'b0);
    run_cmd(8'h33, 4'd4, 0, 8'h00, 0, 1, 1'b0, 1'b0, 1'b0);
    run_cmd(8'hFF, 4'd15, 2, 8'h00, 1, 99, 1'b1, 1'b0, 1'b0);
    run_cmd(8'h44, 4'd3, 0, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the first mailbox ACCESS.
    sl_op = 8'h77; sl_busy = 0; sl_code = 0; sl_waits = 2; sl_err_idx = 99;
    n_wr = 0; n_poll = 0; n_mbx = 0;
    @(posedge CLK); #1;
    CMD_OPCODE = 8'h77; CMD_NWORDS = 4'd4; CMD_START = 1'b1;
    @(posedge CLK); #1 CMD_START = 1'b0;
    t = 0;
    while (!(APBM_PSEL && APBM_PENABLE && APBM_PADDR == 32'h100) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("mbx_access_reached", 32'(t < 200), 32'd1);
    #1 RESETN = 1'b0;
    #1 chk_outputs_zero("async_reset");
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    run_cmd(8'h78, 4'd2, 1, 8'h00, 0, 99, 1'b0, 1'b0, 1'b0);

`ifdef SYSSERV_TIMEOUT_EN
    run_cmd(8'h99, 4'd3, 100000, 8'h00, 0, 99, 1'b0, 1'b0, 1'b1);
`endif

    for (int r = 0; r < 25; r++) begin
      logic [7:0] code;
      int eidx;
      code = ($urandom() % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      eidx = ($urandom() % 4 == 0) ? int'($urandom_range(0, 15)) : 99;
      run_cmd(8'($urandom()), 4'($urandom()), int'($urandom_range(0, 4)), code,
              int'($urandom_range(0, 3)), eidx, 1'($urandom()), 1'b0, 1'b0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
